// File: rtl/proc_pkg.sv
// Shared types and constants for the multi-cycle 9-bit-ISA core.
package proc_pkg;

    localparam int unsigned INSTR_W = 9;
    localparam int unsigned FIELD_W = 3;
    localparam int unsigned OP_LSB  = 6;
    localparam int unsigned A_LSB   = 3;
    localparam int unsigned B_LSB   = 0;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_XOR = 3'd1,
        OP_AND = 3'd2,
        OP_LDI = 3'd3,
        OP_LD  = 3'd4,
        OP_ST  = 3'd5,
        OP_BZ  = 3'd6,
        OP_SYS = 3'd7
    } op_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        HALT  = 3'd4
    } state_t;

    localparam logic [FIELD_W-1:0] SYS_HALT = 3'd0;
    localparam logic [FIELD_W-1:0] SYS_SHL  = 3'd1;
    localparam logic [FIELD_W-1:0] SYS_SHR  = 3'd2;

endpackage

// File: rtl/jump_lut.sv
// Constant branch-target table: 3-bit index to D-bit PC.
module jump_lut #(
    parameter int unsigned D = 12
) (
    input  logic [2:0]   idx,
    output logic [D-1:0] target_c
);

    always_comb begin
        unique case (idx)
            3'd0: target_c = D'(12'h040);
            3'd1: target_c = D'(12'h080);
            3'd2: target_c = D'(12'h0C0);
            3'd3: target_c = D'(12'h100);
            3'd4: target_c = D'(12'h140);
            3'd5: target_c = D'(12'h180);
            3'd6: target_c = D'(12'h1C0);
            3'd7: target_c = D'(12'hFFF);
        endcase
    end

endmodule

// File: rtl/proc_core.sv
// Multi-cycle core: FETCH/EXEC/MEM sequencer with start/done handshake and req/ack data memory.
// Optional watchdog abort built when PROC_WATCHDOG_EN is defined.
module proc_core
    import proc_pkg::*;
#(
    parameter int unsigned D          = 12,
    parameter int unsigned W          = 8,
    parameter int unsigned WDOG_LIMIT = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [D-1:0]       start_addr,
    output logic               done,
    output logic               fault,
    output logic [D-1:0]       imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               dm_req,
    output logic               dm_we,
    output logic [W-1:0]       dm_addr,
    output logic [W-1:0]       dm_wdata,
    input  logic [W-1:0]       dm_rdata,
    input  logic               dm_ack,
    output logic [15:0]        instr_cnt
);

    state_t               state, state_d;
    logic [D-1:0]         pc, pc_d, pc_inc, lut_target;
    logic [W-1:0]         rf [8];
    logic [15:0]          instr_cnt_d, cnt_inc;
    logic                 dm_req_d, dm_we_d;
    logic [W-1:0]         dm_addr_d, dm_wdata_d;
    logic [FIELD_W-1:0]   mem_dst, mem_dst_d;
    logic                 rf_we_c;
    logic [FIELD_W-1:0]   rf_waddr_c;
    logic [W-1:0]         rf_wdata_c;
    logic                 start_ok_c;
    op_t                  op;
    logic [FIELD_W-1:0]   f_a, f_b;
    logic [W-1:0]         rf_a, rf_b;

    assign op         = op_t'(imem_data[OP_LSB +: FIELD_W]);
    assign f_a        = imem_data[A_LSB +: FIELD_W];
    assign f_b        = imem_data[B_LSB +: FIELD_W];
    assign rf_a       = rf[f_a];
    assign rf_b       = rf[f_b];
    assign pc_inc     = pc + D'(1);
    assign cnt_inc    = (instr_cnt == 16'hFFFF) ? instr_cnt : instr_cnt + 16'd1;
    assign imem_addr  = pc;
    assign start_ok_c = start && (state == IDLE || state == HALT);

    jump_lut #(.D(D)) u_jump_lut (
        .idx      (f_b),
        .target_c (lut_target)
    );

`ifdef PROC_WATCHDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_LIMIT) + 1;
    logic [WDOG_W-1:0] wdog_cnt;
    logic              wdog_active_c, wdog_hit_c;

    assign wdog_active_c = (state == FETCH) || (state == EXEC) || (state == MEM);
    assign wdog_hit_c    = wdog_active_c && (wdog_cnt == WDOG_W'(WDOG_LIMIT - 1));

    // Cycle budget per run; fault stays set until the next start or reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_cnt <= '0;
            fault    <= 1'b0;
        end else if (start_ok_c) begin
            wdog_cnt <= '0;
            fault    <= 1'b0;
        end else if (wdog_hit_c) begin
            fault    <= 1'b1;
        end else if (wdog_active_c) begin
            wdog_cnt <= wdog_cnt + WDOG_W'(1);
        end
    end
`else
    assign fault = 1'b0;
`endif

    // Next-state, datapath and register-file write selection.
    always_comb begin
        state_d     = state;
        pc_d        = pc;
        instr_cnt_d = instr_cnt;
        dm_req_d    = dm_req;
        dm_we_d     = dm_we;
        dm_addr_d   = dm_addr;
        dm_wdata_d  = dm_wdata;
        mem_dst_d   = mem_dst;
        rf_we_c     = 1'b0;
        rf_waddr_c  = f_a;
        rf_wdata_c  = '0;

        unique case (state)
            IDLE, HALT: begin
                if (start_ok_c) begin
                    state_d     = FETCH;
                    pc_d        = start_addr;
                    instr_cnt_d = '0;
                end
            end
            FETCH: state_d = EXEC;
            EXEC: begin
                state_d     = FETCH;
                pc_d        = pc_inc;
                instr_cnt_d = cnt_inc;
                unique case (op)
                    OP_ADD: begin rf_we_c = 1'b1; rf_wdata_c = rf_a + rf_b; end
                    OP_XOR: begin rf_we_c = 1'b1; rf_wdata_c = rf_a ^ rf_b; end
                    OP_AND: begin rf_we_c = 1'b1; rf_wdata_c = rf_a & rf_b; end
                    OP_LDI: begin rf_we_c = 1'b1; rf_wdata_c = W'(f_b); end
                    OP_LD, OP_ST: begin
                        state_d     = MEM;
                        pc_d        = pc;
                        instr_cnt_d = instr_cnt;
                        dm_req_d    = 1'b1;
                        dm_we_d     = (op == OP_ST);
                        dm_addr_d   = rf_b;
                        dm_wdata_d  = rf_a;
                        mem_dst_d   = f_a;
                    end
                    OP_BZ: begin
                        if (rf_a == '0) pc_d = lut_target;
                    end
                    OP_SYS: begin
                        case (f_b)
                            SYS_HALT: begin state_d = HALT; pc_d = pc; end
                            SYS_SHL:  begin rf_we_c = 1'b1; rf_wdata_c = rf_a << 1; end
                            SYS_SHR:  begin rf_we_c = 1'b1; rf_wdata_c = rf_a >> 1; end
                            default:  ;
                        endcase
                    end
                endcase
            end
            MEM: begin
                // Request fields stay frozen until the acknowledge.
                if (dm_ack) begin
                    state_d     = FETCH;
                    dm_req_d    = 1'b0;
                    pc_d        = pc_inc;
                    instr_cnt_d = cnt_inc;
                    if (!dm_we) begin
                        rf_we_c    = 1'b1;
                        rf_waddr_c = mem_dst;
                        rf_wdata_c = dm_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef PROC_WATCHDOG_EN
        if (wdog_hit_c) begin
            state_d     = HALT;
            pc_d        = pc;
            instr_cnt_d = instr_cnt;
            dm_req_d    = 1'b0;
            rf_we_c     = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= '0;
            instr_cnt <= '0;
            done      <= 1'b0;
            dm_req    <= 1'b0;
            dm_we     <= 1'b0;
            dm_addr   <= '0;
            dm_wdata  <= '0;
            mem_dst   <= '0;
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            instr_cnt <= instr_cnt_d;
            done      <= (state_d == HALT);
            dm_req    <= dm_req_d;
            dm_we     <= dm_we_d;
            dm_addr   <= dm_addr_d;
            dm_wdata  <= dm_wdata_d;
            mem_dst   <= mem_dst_d;
            if (rf_we_c) rf[rf_waddr_c] <= rf_wdata_c;
        end
    end

endmodule
